// File: rtl/decoder_scan_sequencer_if.sv
// Select/enable bundle between the scan control logic and the sequencer that
// drives the 3-to-8 decoder; the master drives the controls, the slave drives the decoder lines.
interface decoder_scan_sequencer_if #(
  parameter int DWELL_W = 8
);
  logic               start;
  logic               stop;
  logic               loop;
  logic [DWELL_W-1:0] dwell;
  logic               A;
  logic               B;
  logic               C;
  logic               en;
  logic               step;
  logic               busy;
  logic               done;

  modport master (
    output start, stop, loop, dwell,
    input  A, B, C, en, step, busy, done
  );

  modport slave (
    input  start, stop, loop, dwell,
    output A, B, C, en, step, busy, done
  );
endinterface

// File: rtl/decoder_scan_sequencer.sv
// Steps the decoder select {A,B,C} through codes 0..7, each held for a latched dwell count.
// All outputs come straight from flops; the first code appears one cycle after start is sampled.
module decoder_scan_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  decoder_scan_sequencer_if.slave  sif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [2:0]         addr_q,  addr_d;
  logic [DWELL_W-1:0] cnt_q,   cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               loop_q,  loop_d;
  logic               en_q,    en_d;
  logic               busy_q,  busy_d;
  logic               step_q,  step_d;
  logic               done_q,  done_d;
  logic [DWELL_W-1:0] dwell_eff;

  assign dwell_eff = (sif.dwell == '0) ? DWELL_W'(1) : sif.dwell;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    loop_d  = loop_q;
    en_d    = en_q;
    busy_d  = busy_q;
    step_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sif.start && !sif.stop) begin
          state_d = S_RUN;
          dwell_d = dwell_eff;
          loop_d  = sif.loop;
          cnt_d   = dwell_eff - DWELL_W'(1);
          addr_d  = 3'd0;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          step_d  = 1'b1;
        end
      end
      S_RUN: begin
        if (sif.stop) begin
          state_d = S_IDLE;
          addr_d  = 3'd0;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else if (addr_q != 3'd7 || loop_q) begin
          // 7 -> 0 wrap in loop mode falls out of the 3-bit increment
          addr_d = addr_q + 3'd1;
          cnt_d  = dwell_q - DWELL_W'(1);
          step_d = 1'b1;
        end else begin
          state_d = S_DONE;
          addr_d  = 3'd0;
          en_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        addr_d  = 3'd0;
        en_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= 3'd0;
      cnt_q   <= '0;
      dwell_q <= DWELL_W'(1);
      loop_q  <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      loop_q  <= loop_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      step_q  <= step_d;
      done_q  <= done_d;
    end
  end

  assign sif.A    = addr_q[2];
  assign sif.B    = addr_q[1];
  assign sif.C    = addr_q[0];
  assign sif.en   = en_q;
  assign sif.busy = busy_q;
  assign sif.step = step_q;
  assign sif.done = done_q;

endmodule
